csd2bin_arb: RTL and testbench
==============================

# csd2bin_arb

Round-robin / fixed-priority scheduler that shares one `csd2bin` converter among `N` requesters in the BKM FPU datapath. Each requester offers a W-digit CSD operand over a valid/ready handshake. The block grants one requester per cycle, converts the operand combinationally through the shared `csd2bin` instance, and registers the binary result with the requester ID into a single-entry output stage that supports back-pressure.

## Interface
- `W`, 5: number of CSD digits and width of the binary result.
- `N`, 4: number of requesters, N ≥ 2 (need not be a power of two).
- `IDW`, `$clog2(N)`: width of the requester ID (derived, not overridable).

- `clk`  in  1  single clock, rising edge.
- `arst_n`  in  1  reset, asynchronous and active-low.
- `prio_mode`  in  1  arbitration mode: 0 = round-robin, 1 = fixed priority (lowest index wins).
- `req_valid`  in  N  requester i offers an operand.
- `req_x`  in  N·2W  operands; requester i uses bits [2W·i +: 2W].
- `req_ready`  out  N  one-hot grant; requester i is accepted when `req_valid[i] & req_ready[i]`.
- `out_valid`  out  1  the result register holds data.
- `out_y`  out  W  converted binary value.
- `out_id`  out  IDW  index of the requester that produced `out_y`.
- `out_ready`  in  1  downstream accepts the result.

## Operation
- Digit encoding, digit k = `x[2k+1:2k]`: 01 = +1, 10 = −1, 00 or 11 = 0.
- Conversion: y = Σ d_k·2^k mod 2^W, in two's complement, truncated to W bits.
- Output stage can load when `!out_valid | out_ready`.
- When the stage can load, the arbiter picks the winner g among the asserted `req_valid` bits and drives `req_ready = 1<<g`. Otherwise `req_ready = 0`.
- Round-robin search order: ptr, ptr+1, …, N−1, 0, …, ptr−1. The search wraps modulo N, including when N is not a power of two.
- Fixed-priority search order: 0 → N−1.
- On an accept: `out_y ← csd2bin(req_x[g])`, `out_id ← g`, `out_valid ← 1`.
- In round-robin mode, an accept also sets `ptr ← (g+1) mod N`. In fixed-priority mode, ptr holds.
- No accept while `out_valid & out_ready`: `out_valid ← 0`. Accept and drain in the same cycle: the register reloads and `out_valid` stays 1.
- `out_valid & !out_ready`: `out_y` and `out_id` hold stable and `req_ready` is all 0.
- Requesters must hold `req_valid` and `req_x` until they are accepted. If a requester drops `req_valid` before acceptance, the arbiter simply skips it and keeps no state for it.
- A change on `prio_mode` takes effect in the same cycle it changes, because arbitration is combinational. ptr keeps its value across mode changes.

## Timing
- Latency is 1 cycle: an accept at edge t makes the result visible on `out_*` after edge t.
- Throughput is 1 result per cycle while `out_ready` is held high.
- `req_ready` is a combinational function of `req_valid`, `prio_mode`, ptr, `out_valid` and `out_ready`. It has no path from `req_x`.
- Reset values (asynchronous): `out_valid` = 0, `out_y` = 0, `out_id` = 0, ptr = 0.
- While `arst_n` = 0, `req_ready` is forced to 0.
- Reset mid-operation discards any pending result.
- The first cycle after reset release arbitrates normally.

## Structure
- Package `csd2bin_pkg` holds:
  - constants `CSD_POS` = 2'b01, `CSD_NEG` = 2'b10, `CSD_ZERO` = 2'b00;
  - a function `csd_digit_val`, used by the bench reference model.
- Sub-module: a single existing `csd2bin` instance with parameter W. Its input is the granted operand, selected by a one-hot AND-OR mux.
- Arbiter logic (ptr, priority search, one-hot grant) stays inline; no separate arbiter module.

## Test plan
- Single request: `req_valid` = 0001, `req_x[0]` = 10'h102 (+16, −1) → `req_ready` = 0001 for one cycle; next cycle `out_valid` = 1, `out_y` = 15, `out_id` = 0.
- Wrap-around: `req_x[1]` = 10'h2AA (all −1) → `out_y` = 1. `req_x[2]` = 10'h155 (all +1) → `out_y` = 31. All digits 11 → `out_y` = 0.
- Round-robin fairness: `prio_mode` = 0, `req_valid` = 1111 held, `out_ready` = 1 → `out_id` sequence 0, 1, 2, 3, 0, … with one result per cycle. Repeat with N = 3: sequence 0, 1, 2, 0.
- Fixed priority: `prio_mode` = 1, `req_valid` = 1110 → `out_id` = 1 every cycle. Switch to `prio_mode` = 0 after ptr = 2 → next grant is 2.
- Back-pressure: hold `out_ready` = 0 for 5 cycles while requests are pending → `req_ready` = 0 and `out_y`/`out_id` stable. Raise `out_ready` → drain and reload in the same cycle, with `out_valid` staying 1.
- Reset mid-stream: assert `arst_n` = 0 while `out_valid` = 1 → all outputs 0 immediately. After release with `req_valid` = 1111, the first `out_id` is 0.

Source files
------------

// File: rtl/csd2bin_pkg.sv
// csd2bin_pkg: shared CSD digit encodings and helpers for the
// csd2bin converter, its round-robin front end and the bench model.
package csd2bin_pkg;

   localparam logic [1:0] CSD_POS  = 2'b01;
   localparam logic [1:0] CSD_NEG  = 2'b10;
   localparam logic [1:0] CSD_ZERO = 2'b00;

   // 11 is treated as a zero digit, like 00
   function automatic int csd_digit_val(input logic [1:0] d);
      int v;
      v = 0;
      if (d == CSD_POS) v = 1;
      else if (d == CSD_NEG) v = -1;
      return v;
   endfunction

endpackage

// File: rtl/csd2bin_arb_if.sv
// csd2bin_arb_if: requester valid/ready bundle plus the
// registered result channel with back-pressure.
interface csd2bin_arb_if #(
   parameter int W = 5,
   parameter int N = 4
);
   localparam int IDW = $clog2(N);

   logic [N-1:0]     req_valid;
   logic [N*2*W-1:0] req_x;
   logic [N-1:0]     req_ready;
   logic             out_valid;
   logic [W-1:0]     out_y;
   logic [IDW-1:0]   out_id;
   logic             out_ready;

   modport master (
      output req_valid, req_x, out_ready,
      input  req_ready, out_valid, out_y, out_id
   );

   modport slave (
      input  req_valid, req_x, out_ready,
      output req_ready, out_valid, out_y, out_id
   );

endinterface

// File: rtl/csd2bin.sv
// csd2bin: combinational W-digit CSD to W-bit two's complement
// converter, result taken modulo 2^W.
module csd2bin
   import csd2bin_pkg::*;
#(
   parameter int W = 5
) (
   input  logic [2*W-1:0] x,
   output logic [W-1:0]   y
);

   logic [W-1:0] pos;
   logic [W-1:0] neg;

   always_comb begin
      pos = '0;
      neg = '0;
      for (int k = 0; k < W; k++) begin
         pos[k] = (x[2*k +: 2] == CSD_POS);
         neg[k] = (x[2*k +: 2] == CSD_NEG);
      end
   end

   assign y = pos - neg;

endmodule

// File: rtl/csd2bin_arb.sv
// csd2bin_arb: round-robin / fixed-priority sharing of one csd2bin
// converter among N requesters, with a single-entry output register.
module csd2bin_arb
   import csd2bin_pkg::*;
#(
   parameter int W = 5,
   parameter int N = 4
) (
   input logic          clk,
   input logic          arst_n,
   input logic          prio_mode,
   csd2bin_arb_if.slave bus
);

   localparam int IDW = $clog2(N);
   localparam int XW  = 2 * W;

   logic [IDW-1:0] ptr_q, ptr_d;
   logic           out_valid_q, out_valid_d;
   logic [W-1:0]   out_y_q, out_y_d;
   logic [IDW-1:0] out_id_q, out_id_d;

   logic [N-1:0]   grant;
   logic [IDW-1:0] gid;
   logic [XW-1:0]  sel_x;
   logic [W-1:0]   conv_y;
   logic           can_load;
   logic           accept;

   assign can_load = !out_valid_q || bus.out_ready;

   // descending scan so the earliest position in search order wins
   always_comb begin
      int idx;
      idx   = 0;
      grant = '0;
      if (arst_n && can_load) begin
         for (int k = N - 1; k >= 0; k--) begin
            idx = prio_mode ? k : int'(ptr_q) + k;
            if (idx >= N) idx = idx - N;
            if (bus.req_valid[idx]) begin
               grant      = '0;
               grant[idx] = 1'b1;
            end
         end
      end
   end

   always_comb begin
      gid   = '0;
      sel_x = '0;
      for (int i = 0; i < N; i++) begin
         gid   = gid | (IDW'(i) & {IDW{grant[i]}});
         sel_x = sel_x | (bus.req_x[XW*i +: XW] & {XW{grant[i]}});
      end
   end

   assign accept = |grant;

   csd2bin #(.W(W)) u_conv (
      .x (sel_x),
      .y (conv_y)
   );

   always_comb begin
      ptr_d       = ptr_q;
      out_valid_d = out_valid_q;
      out_y_d     = out_y_q;
      out_id_d    = out_id_q;
      if (accept) begin
         out_valid_d = 1'b1;
         out_y_d     = conv_y;
         out_id_d    = gid;
         if (!prio_mode)
            ptr_d = (gid == IDW'(N - 1)) ? '0 : gid + 1'b1;
      end else if (bus.out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         ptr_q       <= '0;
         out_valid_q <= 1'b0;
         out_y_q     <= '0;
         out_id_q    <= '0;
      end else begin
         ptr_q       <= ptr_d;
         out_valid_q <= out_valid_d;
         out_y_q     <= out_y_d;
         out_id_q    <= out_id_d;
      end
   end

   assign bus.req_ready = grant;
   assign bus.out_valid = out_valid_q;
   assign bus.out_y     = out_y_q;
   assign bus.out_id    = out_id_q;

endmodule

// File: tb/tb_csd2bin_arb.sv
// tb_csd2bin_arb: scenario tasks with a result scoreboard for the
// N=4 instance, plus a short round-robin run on an N=3 instance.
module tb_csd2bin_arb;
   import csd2bin_pkg::*;

   typedef struct packed {
      logic [1:0] id;
      logic [4:0] y;
   } exp_t;

   logic clk;
   logic arst_n;
   logic prio_mode;
   logic prio3;

   int   vectors;
   int   errors;
   int   mptr;
   exp_t exp_q[$];

   csd2bin_arb_if #(.W(5), .N(4)) ifc ();
   csd2bin_arb_if #(.W(5), .N(3)) ifc3 ();

   csd2bin_arb #(.W(5), .N(4)) dut (
      .clk       (clk),
      .arst_n    (arst_n),
      .prio_mode (prio_mode),
      .bus       (ifc)
   );

   csd2bin_arb #(.W(5), .N(3)) dut3 (
      .clk       (clk),
      .arst_n    (arst_n),
      .prio_mode (prio3),
      .bus       (ifc3)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [4:0] ref_conv(input logic [9:0] x);
      int s;
      s = 0;
      for (int k = 0; k < 5; k++)
         s = s + csd_digit_val(x[2*k +: 2]) * (1 << k);
      return 5'(s);
   endfunction

   function automatic int pick(input logic [3:0] v, input logic p,
                               input int ptr);
      int r;
      int idx;
      r = -1;
      for (int k = 0; k < 4; k++) begin
         idx = p ? k : (ptr + k) % 4;
         if (r < 0 && v[idx]) r = idx;
      end
      return r;
   endfunction

   // result scoreboard: every transfer on the output channel pops one entry
   always @(negedge clk) begin
      if (arst_n && ifc.out_valid && ifc.out_ready) begin
         vectors++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_extra: got id=%0d y=%0d, expected none",
                     ifc.out_id, ifc.out_y);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if ({ifc.out_id, ifc.out_y} !== e) begin
               errors++;
               $display("FAIL sb_result: got id=%0d y=%0d, expected id=%0d y=%0d",
                        ifc.out_id, ifc.out_y, e.id, e.y);
            end
         end
      end
   end

   task automatic test_reset();
      ifc.req_valid = 4'b1111;
      repeat (2) @(posedge clk);
      @(negedge clk);
      vectors++;
      if ({ifc.req_ready, ifc.out_valid, ifc.out_id, ifc.out_y} !== 12'h0) begin
         errors++;
         $display("FAIL reset_state: got rdy=%b v=%b id=%0d y=%0d, expected all 0",
                  ifc.req_ready, ifc.out_valid, ifc.out_id, ifc.out_y);
      end
      @(posedge clk); #1;
      ifc.req_valid = 4'b0000;
      arst_n = 1'b1;
      mptr = 0;
      @(negedge clk);
      vectors++;
      if (ifc.req_ready !== 4'b0000) begin
         errors++;
         $display("FAIL idle_ready: got %b, expected 0000", ifc.req_ready);
      end
   endtask

   task automatic test_single();
      @(posedge clk); #1;
      ifc.req_x[9:0] = 10'h102;
      ifc.req_valid  = 4'b0001;
      @(negedge clk);
      vectors++;
      if (ifc.req_ready !== 4'b0001) begin
         errors++;
         $display("FAIL single_grant: got %b, expected 0001", ifc.req_ready);
      end
      exp_q.push_back('{id: 2'd0, y: 5'd15});
      mptr = 1;
      @(posedge clk); #1;
      ifc.req_valid = 4'b0000;
      @(negedge clk);
      vectors++;
      if (ifc.req_ready !== 4'b0000) begin
         errors++;
         $display("FAIL single_release: got %b, expected 0000", ifc.req_ready);
      end
   endtask

   task automatic test_wrap();
      logic [9:0] xs[3];
      logic [4:0] ys[3];
      logic [3:0] m;
      xs[0] = 10'h2AA; ys[0] = 5'd1;
      xs[1] = 10'h155; ys[1] = 5'd31;
      xs[2] = 10'h3FF; ys[2] = 5'd0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         ifc.req_x[10*(i+1) +: 10] = xs[i];
         m = 4'b0010 << i;
         ifc.req_valid = m;
         @(negedge clk);
         vectors++;
         if (ifc.req_ready !== m) begin
            errors++;
            $display("FAIL wrap_grant%0d: got %b, expected %b",
                     i + 1, ifc.req_ready, m);
         end
         exp_q.push_back('{id: 2'(i + 1), y: ys[i]});
      end
      mptr = 0;
      @(posedge clk); #1;
      ifc.req_valid = 4'b0000;
      @(negedge clk);
   endtask

   task automatic test_round_robin();
      int g;
      logic [3:0] m;
      @(posedge clk); #1;
      prio_mode = 1'b0;
      for (int i = 0; i < 4; i++)
         ifc.req_x[10*i +: 10] = 10'($urandom_range(0, 1023));
      ifc.req_valid = 4'b1111;
      for (int c = 0; c < 8; c++) begin
         g = pick(4'b1111, 1'b0, mptr);
         m = 4'b0001 << g;
         @(negedge clk);
         vectors++;
         if (ifc.req_ready !== m || g != c % 4) begin
            errors++;
            $display("FAIL rr_grant c%0d: got %b, expected %b",
                     c, ifc.req_ready, m);
         end
         exp_q.push_back('{id: 2'(g), y: ref_conv(ifc.req_x[10*g +: 10])});
         mptr = (g + 1) % 4;
         @(posedge clk); #1;
         ifc.req_x[10*g +: 10] = 10'($urandom_range(0, 1023));
      end
      ifc.req_valid = 4'b0000;
      @(negedge clk);
   endtask

   task automatic test_fixed_prio();
      int g;
      logic [3:0] m;
      @(posedge clk); #1;
      for (int c = 0; c < 7; c++) begin
         prio_mode     = (c >= 1 && c <= 3);
         ifc.req_valid = (c == 0) ? 4'b0010 : 4'b1110;
         g = pick(ifc.req_valid, prio_mode, mptr);
         m = 4'b0001 << g;
         @(negedge clk);
         vectors++;
         if (ifc.req_ready !== m) begin
            errors++;
            $display("FAIL prio_grant c%0d: got %b, expected %b",
                     c, ifc.req_ready, m);
         end
         exp_q.push_back('{id: 2'(g), y: ref_conv(ifc.req_x[10*g +: 10])});
         if (!prio_mode) mptr = (g + 1) % 4;
         @(posedge clk); #1;
      end
      prio_mode     = 1'b0;
      ifc.req_valid = 4'b0000;
      @(negedge clk);
   endtask

   task automatic test_back_pressure();
      int   g;
      exp_t hold;
      exp_t nxt;
      @(posedge clk); #1;
      ifc.out_ready = 1'b0;
      ifc.req_valid = 4'b1111;
      g = pick(4'b1111, 1'b0, mptr);
      @(negedge clk);
      vectors++;
      if (ifc.req_ready !== 4'(4'b0001 << g)) begin
         errors++;
         $display("FAIL bp_first: got %b, expected %b",
                  ifc.req_ready, 4'(4'b0001 << g));
      end
      hold = '{id: 2'(g), y: ref_conv(ifc.req_x[10*g +: 10])};
      exp_q.push_back(hold);
      mptr = (g + 1) % 4;
      @(posedge clk); #1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         vectors++;
         if ({ifc.req_ready, ifc.out_valid, ifc.out_id, ifc.out_y} !==
             {4'b0000, 1'b1, hold.id, hold.y}) begin
            errors++;
            $display("FAIL bp_stall c%0d: got rdy=%b v=%b id=%0d y=%0d, expected rdy=0000 v=1 id=%0d y=%0d",
                     c, ifc.req_ready, ifc.out_valid, ifc.out_id, ifc.out_y,
                     hold.id, hold.y);
         end
         @(posedge clk); #1;
      end
      ifc.out_ready = 1'b1;
      g = pick(4'b1111, 1'b0, mptr);
      @(negedge clk);
      vectors++;
      if (ifc.req_ready !== 4'(4'b0001 << g)) begin
         errors++;
         $display("FAIL bp_reload: got %b, expected %b",
                  ifc.req_ready, 4'(4'b0001 << g));
      end
      nxt = '{id: 2'(g), y: ref_conv(ifc.req_x[10*g +: 10])};
      exp_q.push_back(nxt);
      mptr = (g + 1) % 4;
      @(posedge clk); #1;
      ifc.req_valid = 4'b0000;
      @(negedge clk);
      vectors++;
      if (ifc.out_valid !== 1'b1) begin
         errors++;
         $display("FAIL bp_valid_kept: got %b, expected 1", ifc.out_valid);
      end
   endtask

   task automatic test_reset_mid();
      int g;
      @(posedge clk); #1;
      ifc.out_ready   = 1'b0;
      ifc.req_x[19:10] = 10'h155;
      ifc.req_valid   = 4'b0010;
      @(posedge clk); #1;
      ifc.req_valid = 4'b1111;
      vectors++;
      if ({ifc.out_valid, ifc.out_id, ifc.out_y} !== {1'b1, 2'd1, 5'd31}) begin
         errors++;
         $display("FAIL rst_pre: got v=%b id=%0d y=%0d, expected v=1 id=1 y=31",
                  ifc.out_valid, ifc.out_id, ifc.out_y);
      end
      arst_n = 1'b0;
      #1;
      vectors++;
      if ({ifc.req_ready, ifc.out_valid, ifc.out_id, ifc.out_y} !== 12'h0) begin
         errors++;
         $display("FAIL rst_mid: got rdy=%b v=%b id=%0d y=%0d, expected all 0",
                  ifc.req_ready, ifc.out_valid, ifc.out_id, ifc.out_y);
      end
      mptr = 0;
      @(posedge clk); #1;
      ifc.out_ready = 1'b1;
      arst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         g = pick(4'b1111, 1'b0, mptr);
         @(negedge clk);
         vectors++;
         if (ifc.req_ready !== 4'(4'b0001 << g) || g != c) begin
            errors++;
            $display("FAIL rst_after c%0d: got %b, expected %b",
                     c, ifc.req_ready, 4'(4'b0001 << g));
         end
         exp_q.push_back('{id: 2'(g), y: ref_conv(ifc.req_x[10*g +: 10])});
         mptr = (g + 1) % 4;
         @(posedge clk); #1;
      end
      ifc.req_valid = 4'b0000;
      @(negedge clk);
   endtask

   task automatic test_rr_n3();
      logic [2:0] m;
      int j;
      @(posedge clk); #1;
      ifc3.req_x     = 30'($urandom());
      ifc3.req_valid = 3'b111;
      for (int c = 0; c < 7; c++) begin
         m = (c < 6) ? 3'(3'b001 << (c % 3)) : 3'b000;
         @(negedge clk);
         vectors++;
         if (ifc3.req_ready !== m) begin
            errors++;
            $display("FAIL n3_grant c%0d: got %b, expected %b",
                     c, ifc3.req_ready, m);
         end
         if (c > 0) begin
            j = (c - 1) % 3;
            vectors++;
            if ({ifc3.out_valid, ifc3.out_id, ifc3.out_y} !==
                {1'b1, 2'(j), ref_conv(ifc3.req_x[10*j +: 10])}) begin
               errors++;
               $display("FAIL n3_result c%0d: got v=%b id=%0d y=%0d, expected id=%0d",
                        c, ifc3.out_valid, ifc3.out_id, ifc3.out_y, j);
            end
         end
         @(posedge clk); #1;
         if (c == 5) ifc3.req_valid = 3'b000;
      end
   endtask

   initial begin
      vectors        = 0;
      errors         = 0;
      mptr           = 0;
      arst_n         = 1'b0;
      prio_mode      = 1'b0;
      prio3          = 1'b0;
      ifc.req_valid  = '0;
      ifc.req_x      = '0;
      ifc.out_ready  = 1'b1;
      ifc3.req_valid = '0;
      ifc3.req_x     = '0;
      ifc3.out_ready = 1'b1;

      test_reset();
      test_single();
      test_wrap();
      test_round_robin();
      test_fixed_prio();
      test_back_pressure();
      test_reset_mid();
      test_rr_n3();

      repeat (2) @(negedge clk);
      vectors++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL sb_leftover: got %0d pending, expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
